// File: rtl/fp32_pkg.sv
// Shared binary32 constants and the operand-class type for the floating-point datapath.
package fp32_pkg;

   localparam logic [9:0]  EXP_BIAS = 10'd127;
   localparam logic [7:0]  EXP_MAX  = 8'd255;
   localparam logic [31:0] QNAN     = 32'h7FC00000;
   localparam logic [31:0] POS_INF  = 32'h7F800000;

   typedef enum logic [2:0] {
      ZERO,
      SUB,
      NORMAL,
      INF,
      NAN
   } fp_class_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational binary32 operand decoder: class, sign, biased exponent and
// significand (hidden bit set only for normal operands).
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [31:0] value,
   output fp_class_t   cls,
   output logic        sign,
   output logic [7:0]  expo,
   output logic [23:0] sig
);

   logic [22:0] frac;

   always_comb begin
      frac = value[22:0];
      sign = value[31];
      expo = value[30:23];
      sig  = {1'b0, frac};
      cls  = NORMAL;
      if (expo == '0) begin
         cls = (frac == '0) ? ZERO : SUB;
      end else if (expo == EXP_MAX) begin
         cls = (frac == '0) ? INF : NAN;
      end else begin
         sig = {1'b1, frac};
      end
   end

endmodule

// File: rtl/floating_point_mul.sv
// binary32 multiplier, round-to-nearest-even, flush-to-zero, overflow flag.
// Define FP_MUL_INPUT_REG_EN to register a/b/in_valid first (latency 2 instead of 1).
module floating_point_mul
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] result,
   output logic        overflow
);

   logic        op_valid;
   logic [31:0] op_a;
   logic [31:0] op_b;

`ifdef FP_MUL_INPUT_REG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
      end else begin
         op_valid <= in_valid;
         op_a     <= a;
         op_b     <= b;
      end
   end
`else
   assign op_valid = in_valid;
   assign op_a     = a;
   assign op_b     = b;
`endif

   fp_class_t   cls_a, cls_b;
   logic        sa, sb;
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;

   fp32_classify u_class_a (.value(op_a), .cls(cls_a), .sign(sa), .expo(ea), .sig(ma));
   fp32_classify u_class_b (.value(op_b), .cls(cls_b), .sign(sb), .expo(eb), .sig(mb));

   logic               sign;
   logic [47:0]        prod;
   logic signed [9:0]  exp_sum, exp_norm, exp_fin;
   logic [22:0]        frac_n;
   logic               guard, sticky;
   logic [24:0]        rounded;
   logic [31:0]        res_next;
   logic               other_ok;
   logic               ovf_next;

   always_comb begin
      sign    = sa ^ sb;
      prod    = {24'd0, ma} * {24'd0, mb};
      exp_sum = $signed({2'b00, ea} + {2'b00, eb} - EXP_BIAS);

      if (prod[47]) begin
         frac_n   = prod[46:24];
         guard    = prod[23];
         sticky   = |prod[22:0];
         exp_norm = exp_sum + 10'sd1;
      end else begin
         frac_n   = prod[45:23];
         guard    = prod[22];
         sticky   = |prod[21:0];
         exp_norm = exp_sum;
      end

      // A carry out of rounding leaves the fraction bits all zero, so only the exponent moves.
      rounded = {2'b01, frac_n} + {24'd0, guard & (sticky | frac_n[0])};
      exp_fin = exp_norm + $signed({9'd0, rounded[24]});

      if (cls_a == NAN || cls_b == NAN) begin
         res_next = QNAN;
      end else if ((cls_a == INF && cls_b == ZERO) || (cls_b == INF && cls_a == ZERO)) begin
         res_next = QNAN;
      end else if (cls_a == INF || cls_b == INF) begin
         res_next = {sign, POS_INF[30:0]};
      end else if (cls_a inside {ZERO, SUB} || cls_b inside {ZERO, SUB}) begin
         res_next = '0;
      end else if (exp_fin >= 10'sd255) begin
         res_next = {sign, POS_INF[30:0]};
      end else if (exp_fin <= 10'sd0) begin
         res_next = '0;
      end else begin
         res_next = {sign, exp_fin[7:0], rounded[22:0]};
      end

      if (ea == EXP_MAX)      other_ok = (eb != '0);
      else if (eb == EXP_MAX) other_ok = (ea != '0);
      else                    other_ok = (ea != '0) && (eb != '0);

      ovf_next = (res_next[30:23] == EXP_MAX) && !(ea == EXP_MAX && eb == EXP_MAX) && other_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
      end else begin
         out_valid <= op_valid;
         if (op_valid) begin
            result   <= res_next;
            overflow <= ovf_next;
         end
      end
   end

endmodule

// File: tb/tb_floating_point_mul.sv
// Self-checking bench for floating_point_mul: directed vectors plus randomized
// operands checked against a double-precision reference model every cycle.
module tb_floating_point_mul;

`ifdef FP_MUL_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] a, b;
   logic        out_valid;
   logic [31:0] result;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   floating_point_mul dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(out_valid), .result(result), .overflow(overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
      end
   endtask

   // Reference: returns {overflow, result}. The finite product is formed exactly
   // in double precision and then rounded to 24 significant bits (RNE).
   function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
      logic [7:0]  ex, ey;
      logic [22:0] fx, fy;
      logic        s, nanx, nany, infx, infy, zx, zy;
      logic [31:0] r;
      logic [10:0] dx, dy;
      real         rx, ry;
      logic [63:0] pb;
      logic [28:0] rem;
      logic        up;
      logic [24:0] m;
      int          e32;
      logic        other_ok, ovf;
      ex = x[30:23]; ey = y[30:23];
      fx = x[22:0];  fy = y[22:0];
      s  = x[31] ^ y[31];
      nanx = (ex == 8'hFF) && (fx != 0);
      nany = (ey == 8'hFF) && (fy != 0);
      infx = (ex == 8'hFF) && (fx == 0);
      infy = (ey == 8'hFF) && (fy == 0);
      zx   = (ex == 0) && (fx == 0);
      zy   = (ey == 0) && (fy == 0);
      if (nanx || nany)                    r = 32'h7FC00000;
      else if ((infx && zy) || (infy && zx)) r = 32'h7FC00000;
      else if (infx || infy)               r = {s, 31'h7F800000};
      else if (ex == 0 || ey == 0)         r = 32'h0;
      else begin
         dx = {3'b000, ex} + 11'd896;
         dy = {3'b000, ey} + 11'd896;
         rx = $bitstoreal({1'b0, dx, fx, 29'd0});
         ry = $bitstoreal({1'b0, dy, fy, 29'd0});
         pb = $realtobits(rx * ry);
         rem = pb[28:0];
         up  = (rem > 29'h10000000) || (rem == 29'h10000000 && pb[29]);
         m   = {2'b01, pb[51:29]} + {24'd0, up};
         e32 = int'(pb[62:52]) - 896 + int'(m[24]);
         if (e32 >= 255)     r = {s, 31'h7F800000};
         else if (e32 <= 0)  r = 32'h0;
         else                r = {s, 8'(e32), m[22:0]};
      end
      if (ex == 8'hFF)      other_ok = (ey != 0);
      else if (ey == 8'hFF) other_ok = (ex != 0);
      else                  other_ok = (ex != 0) && (ey != 0);
      ovf = (r[30:23] == 8'hFF) && !(ex == 8'hFF && ey == 8'hFF) && other_ok;
      return {ovf, r};
   endfunction

   // Expected-output delay line: out_valid is in_valid delayed by LAT cycles.
   logic        vpipe [0:1];
   logic [32:0] epipe [0:1];
   logic [32:0] held;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            vpipe[i] <= 1'b0;
            epipe[i] <= '0;
         end
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            vpipe[i] <= vpipe[i-1];
            epipe[i] <= epipe[i-1];
         end
         vpipe[0] <= in_valid;
         epipe[0] <= model(a, b);
      end
   end

   always @(negedge clk) begin
      logic [32:0] want;
      if (rst) begin
         held <= '0;
      end else begin
         want = vpipe[LAT-1] ? epipe[LAT-1] : held;
         check("out_valid", {31'd0, out_valid}, {31'd0, vpipe[LAT-1]});
         check("result", result, want[31:0]);
         check("overflow", {31'd0, overflow}, {31'd0, want[32]});
         held <= want;
      end
   end

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] r;
      logic        o;
   } vec_t;

   vec_t vecs [0:17];

   function automatic logic [31:0] rnd_op();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 7))
         0: begin v[30:23] = 8'h00; if ($urandom_range(0, 1) == 1) v[22:0] = '0; end
         1: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) v[22:0] = '0; end
         2: v[22:0]  = '0;
         3: v[30:23] = 8'($urandom_range(1, 20));
         4: v[30:23] = 8'($urandom_range(235, 254));
         5: v[30:23] = 8'($urandom_range(100, 154));
         default: ;
      endcase
      return v;
   endfunction

   initial begin
      logic [32:0] mv;
      vecs[0]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
      vecs[1]  = '{32'h00000000, 32'h3F800000, 32'h00000000, 1'b0};
      vecs[2]  = '{32'h00000000, 32'hBF800000, 32'h00000000, 1'b0};
      vecs[3]  = '{32'h3F800000, 32'h40000000, 32'h40000000, 1'b0};
      vecs[4]  = '{32'hBF800000, 32'hBF800000, 32'h3F800000, 1'b0};
      vecs[5]  = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0};
      vecs[6]  = '{32'h41200000, 32'hC1A00000, 32'hC3480000, 1'b0};
      vecs[7]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b1};
      vecs[8]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0};
      vecs[9]  = '{32'h7F800000, 32'h00000001, 32'h7F800000, 1'b0};
      vecs[10] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1};
      vecs[11] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 1'b0};
      vecs[12] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 1'b0};
      vecs[13] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1};
      vecs[14] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0};
      vecs[15] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0};
      vecs[16] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1};
      vecs[17] = '{32'h80000000, 32'hFF800000, 32'h7FC00000, 1'b0};

      rst = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      #1 rst = 1'b1;
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;

      // Pin the reference model to hand-computed values.
      foreach (vecs[i]) begin
         mv = model(vecs[i].x, vecs[i].y);
         check("model_result", mv[31:0], vecs[i].r);
         check("model_overflow", {31'd0, mv[32]}, {31'd0, vecs[i].o});
      end

      // Directed vectors back-to-back through the DUT.
      foreach (vecs[i]) begin
         @(negedge clk);
         in_valid = 1'b1; a = vecs[i].x; b = vecs[i].y;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);

      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 3) != 0);
         a = rnd_op();
         b = rnd_op();
         if (n == 1500) begin
            in_valid = 1'b1;
            @(posedge clk);
            #2 rst = 1'b1;
            in_valid = 1'b0;
            #1;
            check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
            check("midreset_result", result, 32'd0);
            check("midreset_overflow", {31'd0, overflow}, 32'd0);
            @(negedge clk);
            #1 rst = 1'b0;
         end
      end

      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
